// File: rtl/sub_bytes_seq.sv
// AES SubBytes / InvSubBytes engine: a 128-bit block is substituted in place,
// LANES bytes per cycle, behind a valid/ready handshake on both sides.
module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    // state | meaning
    // ------+-----------------------------------------------
    // IDLE  | no block held, ready to accept
    // RUN   | substituting LANES bytes of the block per cycle
    // DONE  | result valid on state_out, waiting for out_ready

    localparam int NPASS = 16 / LANES;
    localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int LW    = 8 * LANES;
    localparam logic [CW-1:0] LAST = CW'(NPASS - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            mode;
    logic [127:0]    wr;
    logic [6:0]      base;
    logic [LW-1:0]   lane_in, lane_out;
    logic            accept;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 by square-and-multiply; zero falls out as zero
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic m);
        return m ? gf_inv(aff_inv(x)) : aff_fwd(gf_inv(x));
    endfunction

    assign base    = 7'(32'(cnt) * LW);
    assign lane_in = wr[base +: LW];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_out[8*j +: 8] = sbox(lane_in[8*j +: 8], mode);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RUN;
            S_RUN:  if (cnt == LAST) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = accept ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
        out_valid = (state == S_DONE);
        busy      = (state == S_RUN);
    end

    assign accept    = in_valid & in_ready;
    assign state_out = wr;

    // counter saturates on the last pass so it never wraps inside a block
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            mode <= 1'b0;
            wr   <= '0;
        end else if (accept) begin
            cnt  <= '0;
            mode <= inv;
            wr   <= state_in;
        end else if (state == S_RUN) begin
            wr[base +: LW] <= lane_out;
            if (cnt != LAST) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: three instances (LANES 4, 1, 16) share stimulus and
// are compared against a brute-force GF(2^8) S-box model.
module tb_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         rst_n, in_valid, inv, out_ready;
    logic [127:0] state_in;
    logic         ir[3], ov[3], bz[3];
    logic [127:0] so[3];
    logic [127:0] res_q[3];
    int           lat_q[3];
    int           lanes_of[3] = '{4, 1, 16};
    logic [7:0]   fwd_t[256], inv_t[256];
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    sub_bytes_seq #(.LANES(4)) u_l4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .inv(inv), .state_in(state_in), .out_valid(ov[0]), .out_ready(out_ready),
        .state_out(so[0]), .busy(bz[0]));
    sub_bytes_seq #(.LANES(1)) u_l1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .inv(inv), .state_in(state_in), .out_valid(ov[1]), .out_ready(out_ready),
        .state_out(so[1]), .busy(bz[1]));
    sub_bytes_seq #(.LANES(16)) u_l16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .inv(inv), .state_in(state_in), .out_valid(ov[2]), .out_ready(out_ready),
        .state_out(so[2]), .busy(bz[2]));

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int k = 15; k >= 8; k--) if (prod[k]) prod = prod ^ (16'h11b << (k - 8));
        return prod[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] v, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++) if (x != 0 && ref_mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
            fwd_t[x] = s;
            inv_t[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic m);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = m ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_block(input logic [127:0] d, input logic m);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ir[k] !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_before_accept lanes=%0d: got %b, expected 1", lanes_of[k], ir[k]);
            end
        end
        in_valid = 1'b1; inv = m; state_in = d; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // offers junk on the input the whole time to show RUN/DONE ignore it
    task automatic wait_done();
        bit all_done;
        for (int k = 0; k < 3; k++) lat_q[k] = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            in_valid = 1'b1; inv = 1'($urandom_range(1)); state_in = rnd128();
            @(posedge clk); #1;
            all_done = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (lat_q[k] == 0 && ov[k] === 1'b1) begin lat_q[k] = cyc; res_q[k] = so[k]; end
                if (lat_q[k] == 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (lat_q[k] != 16 / lanes_of[k]) begin
                errors++;
                $display("FAIL latency lanes=%0d: got %0d cycles (0 = timeout), expected %0d",
                         lanes_of[k], lat_q[k], 16 / lanes_of[k]);
            end
        end
    endtask

    task automatic run_block(input logic [127:0] d, input logic m);
        logic [127:0] exp;
        exp = model(d, m);
        start_block(d, m);
        wait_done();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res_q[k] !== exp) begin
                errors++;
                $display("FAIL result lanes=%0d inv=%b in=%h: got %h, expected %h", lanes_of[k], m, d, res_q[k], exp);
            end
        end
    endtask

    task automatic finish_block(input logic [127:0] exp);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || so[k] !== exp) begin
                errors++;
                $display("FAIL after_handshake lanes=%0d: got ov=%b ir=%b out=%h, expected ov=0 ir=1 out=%h",
                         lanes_of[k], ov[k], ir[k], so[k], exp);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; inv = 1'b0; out_ready = 1'b0; state_in = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || bz[k] !== 1'b0 || so[k] !== 128'h0) begin
                errors++;
                $display("FAIL reset_outputs lanes=%0d: got ov=%b busy=%b out=%h, expected 0 0 0",
                         lanes_of[k], ov[k], bz[k], so[k]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release lanes=%0d: got ir=%b ov=%b, expected 1 0", lanes_of[k], ir[k], ov[k]);
            end
        end
    endtask

    task automatic test_vector();
        logic [127:0] a, d;
        a = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        d = 128'hd42711aee0bf98f1b8b45de51e415230;
        run_block(a, 1'b0);
        checks++;
        if (res_q[0] !== d) begin
            errors++;
            $display("FAIL known_vector_fwd: got %h, expected %h", res_q[0], d);
        end
        finish_block(d);
        run_block(d, 1'b1);
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (res_q[k] !== a) begin
                errors++;
                $display("FAIL known_vector_inv lanes=%0d: got %h, expected %h", lanes_of[k], res_q[k], a);
            end
        end
        finish_block(a);
    endtask

    task automatic test_spot();
        logic [127:0] d;
        d = rnd128();
        d[23:0] = 24'hff_53_00;
        run_block(d, 1'b0);
        checks++;
        if (res_q[0][23:0] !== 24'h16_ed_63) begin
            errors++;
            $display("FAIL spot_fwd: got %h, expected 16ed63", res_q[0][23:0]);
        end
        finish_block(res_q[0]);
        d[15:0] = 16'hed_63;
        run_block(d, 1'b1);
        checks++;
        if (res_q[0][15:0] !== 16'h53_00) begin
            errors++;
            $display("FAIL spot_inv: got %h, expected 5300", res_q[0][15:0]);
        end
        finish_block(res_q[0]);
    endtask

    task automatic test_sweep();
        logic [127:0] d;
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 16; b++) begin
                for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(b * 16 + ((i + b) % 16));
                run_block(d, 1'(m));
                finish_block(model(d, 1'(m)));
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic         m;
        for (int n = 0; n < 20; n++) begin
            d = rnd128();
            m = 1'($urandom_range(1));
            run_block(d, m);
            finish_block(model(d, m));
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b, ea, eb;
        logic         ma, mb;
        a = rnd128(); b = rnd128();
        ma = 1'($urandom_range(1)); mb = 1'($urandom_range(1));
        ea = model(a, ma); eb = model(b, mb);
        run_block(a, ma);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; state_in = rnd128(); inv = 1'($urandom_range(1));
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ov[k] !== 1'b1 || ir[k] !== 1'b0 || so[k] !== ea) begin
                    errors++;
                    $display("FAIL done_hold lanes=%0d cyc=%0d: got ov=%b ir=%b out=%h, expected 1 0 %h",
                             lanes_of[k], c, ov[k], ir[k], so[k], ea);
                end
            end
        end
        in_valid = 1'b1; state_in = b; inv = mb; out_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ir[k] !== 1'b1) begin
                errors++;
                $display("FAIL done_ready lanes=%0d: got ir=%b, expected 1", lanes_of[k], ir[k]);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bz[k] !== 1'b1 || ov[k] !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back lanes=%0d: got busy=%b ov=%b, expected 1 0", lanes_of[k], bz[k], ov[k]);
            end
        end
        wait_done();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res_q[k] !== eb) begin
                errors++;
                $display("FAIL back_to_back_result lanes=%0d: got %h, expected %h", lanes_of[k], res_q[k], eb);
            end
        end
        finish_block(eb);
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        d = rnd128();
        start_block(d, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ov[k] !== 1'b0 || bz[k] !== 1'b0 || so[k] !== 128'h0) begin
                    errors++;
                    $display("FAIL reset_mid lanes=%0d cyc=%0d: got ov=%b busy=%b out=%h, expected 0 0 0",
                             lanes_of[k], c, ov[k], bz[k], so[k]);
                end
            end
            @(posedge clk); #1;
        end
        d = rnd128();
        run_block(d, 1'b1);
        finish_block(model(d, 1'b1));
    endtask

    initial begin
        build_tables();
        test_reset();
        test_vector();
        test_spot();
        test_sweep();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
